// File: rtl/dp_pipe16_if.sv
`default_nettype none
// ============================================================================
//  Module   : dp_pipe16_if
//  Purpose  : Handshake/data bundle for the dp_pipe16 pipeline stage.
//             Upstream side:   in_valid / in_ready / in_data
//             Downstream side: out_valid / out_ready / out_data
//             Control/status:  flush, occupancy
//  Modports : master - the environment around the stage (drives inputs)
//             slave  - the dp_pipe16 stage itself
//  Revision : 1.0 - initial release
// ============================================================================
interface dp_pipe16_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/dp_pipe16.sv
`default_nettype none
// ============================================================================
//  Module   : dp_pipe16
//  Purpose  : 16-bit datapath pipeline stage with a 2-entry skid buffer.
//             Registers vector slice data ahead of the j_ni01 driver buffer.
//             All outputs decode from registers only, so there is no
//             combinational path from out_ready to in_ready.
//  Ports    : clk   - datapath clock
//             reset - synchronous active-high reset
//             bus   - dp_pipe16_if.slave (flush, in_*, out_*, occupancy)
//  Revision : 1.0 - initial release
// ============================================================================
module dp_pipe16 #(
  // Only 16 is supported; must match the downstream driver buffer width.
  parameter int WIDTH = 16
) (
  input  wire          clk,
  input  wire          reset,
  dp_pipe16_if.slave   bus
);

  localparam logic [1:0] C_CNT_EMPTY = 2'd0;
  localparam logic [1:0] C_CNT_ONE   = 2'd1;
  localparam logic [1:0] C_CNT_FULL  = 2'd2;

  logic [WIDTH-1:0] h_q, h_d;     // head entry, drives out_data
  logic [WIDTH-1:0] s_q, s_d;     // skid entry, catches the word in flight on a stall
  logic [1:0]       count_q, count_d;
  logic             reset_q;      // holds in_ready low for one cycle after reset

  logic w_push;
  logic w_pop;
  logic w_in_ready;
  logic w_out_valid;

  assign w_in_ready  = (count_q != C_CNT_FULL) & ~reset_q;
  assign w_out_valid = (count_q != C_CNT_EMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = h_q;
  assign bus.occupancy = count_q;

  // Next-state selection. Flush only clears the count; H and S keep their
  // stale contents, which is harmless because out_valid is low.
  always_comb begin
    h_d     = h_q;
    s_d     = s_q;
    count_d = count_q;
    if (bus.flush) begin
      count_d = C_CNT_EMPTY;
    end else begin
      case (count_q)
        C_CNT_EMPTY: begin
          if (w_push) begin
            h_d     = bus.in_data;
            count_d = C_CNT_ONE;
          end
        end
        C_CNT_ONE: begin
          if (w_push && !w_pop) begin
            s_d     = bus.in_data;
            count_d = C_CNT_FULL;
          end else if (w_push && w_pop) begin
            h_d     = bus.in_data;
          end else if (w_pop) begin
            count_d = C_CNT_EMPTY;
          end
        end
        C_CNT_FULL: begin
          // in_ready is low here, so a pop is the only possible event.
          if (w_pop) begin
            h_d     = s_q;
            count_d = C_CNT_ONE;
          end
        end
        default: begin
          count_d = C_CNT_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      h_q     <= '0;
      s_q     <= '0;
      count_q <= C_CNT_EMPTY;
    end else begin
      h_q     <= h_d;
      s_q     <= s_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_pipe16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_pipe16
//  Purpose  : Directed self-checking bench for dp_pipe16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dp_pipe16;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dp_pipe16_if #(.WIDTH(16)) bus ();

  dp_pipe16 #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 16'h0;
    bus.out_ready  = 1'b0;

    // ---- reset, then single word ----
    step();
    step();
    chk("rst_out_data",  bus.out_data,  16'h0000);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b0);
    chk("rst_occ",       bus.occupancy, 2'd0);
    reset = 1'b0;
    chk("rst_release_in_ready0", bus.in_ready, 1'b0);
    step();
    chk("rst_release_in_ready1", bus.in_ready, 1'b1);
    push(16'hA5C3);
    chk("single_valid", bus.out_valid, 1'b1);
    chk("single_data",  bus.out_data,  16'hA5C3);
    chk("single_occ",   bus.occupancy, 2'd1);
    bus.out_ready = 1'b1;
    step();
    chk("single_drain_occ", bus.occupancy, 2'd0);

    // ---- streaming, one word per cycle ----
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      step();
      chk("stream_data",  bus.out_data,  32'(i));
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_occ",   bus.occupancy, 2'd1);
      chk("stream_rdy",   bus.in_ready,  1'b1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_end_occ", bus.occupancy, 2'd0);

    // ---- stall fill ----
    bus.out_ready = 1'b0;
    push(16'h1111);
    push(16'h2222);
    chk("fill_occ",  bus.occupancy, 2'd2);
    chk("fill_rdy",  bus.in_ready,  1'b0);
    chk("fill_head", bus.out_data,  16'h1111);
    push(16'h3333);            // offered while full: must be ignored
    chk("fill_ignored_occ",  bus.occupancy, 2'd2);
    chk("fill_stable_head",  bus.out_data,  16'h1111);
    bus.out_ready = 1'b1;
    step();
    chk("release_w2",     bus.out_data,  16'h2222);
    chk("release_w2_occ", bus.occupancy, 2'd1);
    step();
    chk("release_empty", bus.out_valid, 1'b0);
    push(16'h3333);
    chk("reoffer_data", bus.out_data,  16'h3333);
    chk("reoffer_occ",  bus.occupancy, 2'd1);
    step();
    chk("reoffer_drain", bus.occupancy, 2'd0);

    // ---- simultaneous push/pop at count 1 ----
    bus.out_ready = 1'b0;
    push(16'hBEEF);
    chk("pp_head", bus.out_data, 16'hBEEF);
    bus.out_ready = 1'b1;
    push(16'hCAFE);
    chk("pp_data", bus.out_data,  16'hCAFE);
    chk("pp_occ",  bus.occupancy, 2'd1);
    step();
    chk("pp_drain", bus.occupancy, 2'd0);

    // ---- flush collision ----
    bus.out_ready = 1'b0;
    push(16'h5555);
    push(16'h6666);
    chk("fl_pre_occ", bus.occupancy, 2'd2);
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h7777;
    bus.out_ready = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_occ",   bus.occupancy, 2'd0);
    chk("fl_valid", bus.out_valid, 1'b0);
    chk("fl_rdy",   bus.in_ready,  1'b1);
    chk("fl_head_kept", bus.out_data, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_emerge", bus.out_valid, 1'b0);
    end

    // ---- reset mid-stall ----
    bus.out_ready = 1'b0;
    push(16'h8888);
    push(16'h9999);
    chk("rs_pre_occ", bus.occupancy, 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_valid", bus.out_valid, 1'b0);
    chk("rs_data",  bus.out_data,  16'h0000);
    chk("rs_occ",   bus.occupancy, 2'd0);
    chk("rs_rdy0",  bus.in_ready,  1'b0);
    bus.out_ready = 1'b1;
    step();
    chk("rs_rdy1", bus.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_no_emerge", bus.out_valid, 1'b0);
    end
    push(16'hABCD);
    chk("rs_after_data", bus.out_data,  16'hABCD);
    chk("rs_after_occ",  bus.occupancy, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
